// File: rtl/mt_err_pkg.sv
// rtl/mt_err_pkg.sv - MTER bit indices, default hard-zero mask and write-mode enum
package mt_err_pkg;

  localparam int MTER_ILF    = 0;
  localparam int MTER_ILR    = 1;
  localparam int MTER_RMR    = 2;
  localparam int MTER_CPAR   = 3;
  localparam int MTER_FMT    = 4;
  localparam int MTER_DPAR   = 5;
  localparam int MTER_INCVPE = 6;
  localparam int MTER_PEFLRC = 7;
  localparam int MTER_NSG    = 8;
  localparam int MTER_FCE    = 9;
  localparam int MTER_CSITM  = 10;
  localparam int MTER_NEF    = 11;
  localparam int MTER_DTE    = 12;
  localparam int MTER_OPI    = 13;
  localparam int MTER_UNS    = 14;
  localparam int MTER_CORCRC = 15;

  localparam logic [15:0] MTER_HARDZERO = 16'h8524;

  typedef enum logic {
    W1C_LOAD  = 1'b0,
    W1C_CLEAR = 1'b1
  } w1c_mode_e;

  // Index width that stays legal for a 1-bit register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mt_err_prienc.sv
// rtl/mt_err_prienc.sv - lowest-set-bit encoder feeding first-error capture
module mt_err_prienc #(
  parameter int NBITS = 16,
  parameter int IDXW  = mt_err_pkg::idx_width(NBITS)
) (
  input  logic [NBITS-1:0] vec_i,
  output logic [IDXW-1:0]  idx_o,
  output logic             valid_o
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx_o   = '0;
    valid_o = |vec_i;
    for (int i = NBITS - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDXW'(i);
    end
  end

endmodule

// File: rtl/mt_error_collector.sv
// rtl/mt_error_collector.sv - sticky drive error register with RMR, attention,
// first-error capture and saturating event counter
module mt_error_collector
  import mt_err_pkg::*;
#(
  parameter int               NBITS    = 16,
  parameter int               CNTW     = 8,
  parameter logic [NBITS-1:0] HARDZERO = NBITS'(MTER_HARDZERO),
  parameter int               RMR_BIT  = MTER_RMR,
  parameter w1c_mode_e        W1C      = W1C_LOAD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        init,
  input  logic [NBITS-1:0]            errSET,
  input  logic                        busy,
  input  logic                        regWR,
  input  logic [NBITS-1:0]            regDATA,
  input  logic [NBITS-1:0]            attnMASK,
  input  logic                        attnACK,
  input  logic                        cntCLR,
  output logic [NBITS-1:0]            errREG,
  output logic                        errANY,
  output logic                        attn,
  output logic                        firstVLD,
  output logic [idx_width(NBITS)-1:0] firstIDX,
  output logic [CNTW-1:0]             errCNT
);

  localparam int               IDXW     = idx_width(NBITS);
  localparam logic [NBITS-1:0] RMR_MASK = NBITS'(1) << RMR_BIT;
  // RMR is produced by this block itself, so it is never treated as unimplemented.
  localparam logic [NBITS-1:0] HZ       = HARDZERO & ~RMR_MASK;
  localparam logic [CNTW-1:0]  CNT_MAX  = '1;

  logic             clr;
  logic [NBITS-1:0] eff_set;
  logic [NBITS-1:0] wr_res;
  logic [NBITS-1:0] new_bits;
  logic [IDXW-1:0]  new_idx;
  logic             new_any;

  logic [NBITS-1:0] err_q, err_d;
  logic             attn_q, attn_d;
  logic             vld_q, vld_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  assign clr = rst | init;

  always_comb begin
    eff_set = errSET & ~HZ;
    if (regWR && busy) eff_set = eff_set | RMR_MASK;
  end

  always_comb begin
    wr_res = err_q;
    if (regWR && !busy) begin
      wr_res = (W1C == W1C_CLEAR) ? (err_q & ~regDATA) : (regDATA & ~HZ);
    end
  end

  assign new_bits = eff_set & ~err_q;

  mt_err_prienc #(
    .NBITS(NBITS),
    .IDXW (IDXW)
  ) u_prienc (
    .vec_i  (new_bits),
    .idx_o  (new_idx),
    .valid_o(new_any)
  );

  // Set pulses win over a same-cycle write clear on a per-bit basis.
  assign err_d = clr ? '0 : ((wr_res | eff_set) & ~HZ);

  always_comb begin
    attn_d = attn_q;
    if (attnACK) attn_d = 1'b0;
    if (|(new_bits & attnMASK)) attn_d = 1'b1;
    if (clr) attn_d = 1'b0;
  end

  // A write that empties the register re-arms capture in the same cycle.
  always_comb begin
    vld_d = vld_q && (wr_res != '0);
    idx_d = idx_q;
    if (!vld_d && new_any) begin
      vld_d = 1'b1;
      idx_d = new_idx;
    end
    if (clr) begin
      vld_d = 1'b0;
      idx_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cntCLR) begin
      cnt_d = new_any ? CNTW'(1) : '0;
    end else if (new_any && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNTW'(1);
    end
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk) err_q  <= err_d;
  always_ff @(posedge clk) attn_q <= attn_d;
  always_ff @(posedge clk) vld_q  <= vld_d;
  always_ff @(posedge clk) idx_q  <= idx_d;
  always_ff @(posedge clk) cnt_q  <= cnt_d;

  assign errREG   = err_q;
  assign errANY   = |err_q;
  assign attn     = attn_q;
  assign firstVLD = vld_q;
  assign firstIDX = idx_q;
  assign errCNT   = cnt_q;

endmodule

// File: tb/tb_mt_error_collector.sv
// tb/tb_mt_error_collector.sv - randomized bench for mt_error_collector against a behavioural model
module tb_mt_error_collector;
  import mt_err_pkg::*;

  localparam logic [15:0] HZ = 16'h8520;

  logic        clk = 1'b0;
  logic        rst, init, busy, regWR, attnACK, cntCLR;
  logic [15:0] errSET, regDATA, attnMASK;

  logic [15:0] reg_o  [3];
  logic        any_o  [3];
  logic        attn_o [3];
  logic        vld_o  [3];
  logic [3:0]  idx_o  [3];
  logic [7:0]  cnt0, cnt1;
  logic [1:0]  cnt2;

  logic [15:0] m_reg  [3];
  logic        m_attn [3];
  logic        m_vld  [3];
  int          m_idx  [3];
  int          m_cnt  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mt_error_collector #(.W1C(W1C_LOAD)) u0 (
    .clk(clk), .rst(rst), .init(init), .errSET(errSET), .busy(busy), .regWR(regWR),
    .regDATA(regDATA), .attnMASK(attnMASK), .attnACK(attnACK), .cntCLR(cntCLR),
    .errREG(reg_o[0]), .errANY(any_o[0]), .attn(attn_o[0]), .firstVLD(vld_o[0]),
    .firstIDX(idx_o[0]), .errCNT(cnt0)
  );

  mt_error_collector #(.W1C(W1C_CLEAR)) u1 (
    .clk(clk), .rst(rst), .init(init), .errSET(errSET), .busy(busy), .regWR(regWR),
    .regDATA(regDATA), .attnMASK(attnMASK), .attnACK(attnACK), .cntCLR(cntCLR),
    .errREG(reg_o[1]), .errANY(any_o[1]), .attn(attn_o[1]), .firstVLD(vld_o[1]),
    .firstIDX(idx_o[1]), .errCNT(cnt1)
  );

  mt_error_collector #(.CNTW(2)) u2 (
    .clk(clk), .rst(rst), .init(init), .errSET(errSET), .busy(busy), .regWR(regWR),
    .regDATA(regDATA), .attnMASK(attnMASK), .attnACK(attnACK), .cntCLR(cntCLR),
    .errREG(reg_o[2]), .errANY(any_o[2]), .attn(attn_o[2]), .firstVLD(vld_o[2]),
    .firstIDX(idx_o[2]), .errCNT(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int k);
    return (k == 0) ? int'(cnt0) : (k == 1) ? int'(cnt1) : int'(cnt2);
  endfunction

  // Reference: apply the register rules once per clock using plain integer arithmetic.
  task automatic model_step(input int k);
    logic [15:0] set, wr, nw;
    int          cmax, low;
    if (rst || init) begin
      m_reg[k] = 0; m_attn[k] = 0; m_vld[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
      return;
    end
    cmax = (k == 2) ? 3 : 255;
    set  = errSET & ~HZ;
    if (regWR && busy) set = set | 16'h0004;
    wr = m_reg[k];
    if (regWR && !busy) wr = (k == 1) ? (m_reg[k] & ~regDATA) : (regDATA & ~HZ);
    nw = set & ~m_reg[k];
    if ((nw & attnMASK) != 0) m_attn[k] = 1;
    else if (attnACK) m_attn[k] = 0;
    if (wr == 0) m_vld[k] = 0;
    if (!m_vld[k] && nw != 0) begin
      low = 0;
      while (nw[low] == 1'b0) low++;
      m_idx[k] = low;
      m_vld[k] = 1;
    end
    if (cntCLR) m_cnt[k] = (nw != 0) ? 1 : 0;
    else if (nw != 0 && m_cnt[k] < cmax) m_cnt[k] = m_cnt[k] + 1;
    m_reg[k] = (wr | set) & ~HZ;
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reg%0d", k),  32'(reg_o[k]),  32'(m_reg[k]));
      chk($sformatf("any%0d", k),  32'(any_o[k]),  32'(m_reg[k] != 0));
      chk($sformatf("attn%0d", k), 32'(attn_o[k]), 32'(m_attn[k]));
      chk($sformatf("vld%0d", k),  32'(vld_o[k]),  32'(m_vld[k]));
      chk($sformatf("idx%0d", k),  32'(idx_o[k]),  32'(m_idx[k]));
      chk($sformatf("cnt%0d", k),  32'(cnt_of(k)), 32'(m_cnt[k]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    check_all();
  endtask

  task automatic idle();
    rst = 0; init = 0; errSET = 0; busy = 0; regWR = 0; regDATA = 0;
    attnACK = 0; cntCLR = 0;
  endtask

  initial begin
    idle();
    attnMASK = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      m_reg[k] = 0; m_attn[k] = 0; m_vld[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
    end

    rst = 1; errSET = 16'hFFFF; cyc();
    chk("rst_reg", 32'(reg_o[0]), 0);
    chk("rst_cnt", 32'(cnt0), 0);
    chk("rst_vld", 32'(vld_o[0]), 0);
    idle(); errSET = 16'h0001; cyc();
    init = 1; errSET = 16'hFFFF; cyc();
    chk("init_reg", 32'(reg_o[0]), 0);
    chk("init_cnt", 32'(cnt0), 0);

    idle(); attnMASK = 16'h0800; errSET = 16'h0801; cyc();
    chk("t2_reg", 32'(reg_o[0]), 32'h0801);
    chk("t2_any", 32'(any_o[0]), 1);
    chk("t2_idx", 32'(idx_o[0]), 0);
    chk("t2_vld", 32'(vld_o[0]), 1);
    chk("t2_cnt", 32'(cnt0), 1);
    chk("t2_attn", 32'(attn_o[0]), 1);

    idle(); errSET = 16'h8000; cyc();
    chk("hz_reg", 32'(reg_o[0]), 32'h0801);
    chk("hz_cnt", 32'(cnt0), 1);

    idle(); busy = 1; regWR = 1; regDATA = 0; cyc();
    chk("rmr_reg", 32'(reg_o[0]), 32'h0805);
    idle(); regWR = 1; regDATA = 0; cyc();
    chk("clr_reg", 32'(reg_o[0]), 0);
    chk("clr_vld", 32'(vld_o[0]), 0);

    idle(); attnACK = 1; cyc();
    chk("ack_attn", 32'(attn_o[0]), 0);
    idle(); attnACK = 1; errSET = 16'h0800; cyc();
    chk("ack_set_attn", 32'(attn_o[0]), 1);

    idle(); errSET = 16'h0001; cyc();
    idle(); regWR = 1; regDATA = 16'h0001; errSET = 16'h0001; cyc();
    chk("w1c_set_wins", 32'(reg_o[1][0]), 1);
    idle(); regWR = 1; regDATA = 16'h0001; cyc();
    chk("w1c_clear", 32'(reg_o[1][0]), 0);

    idle(); rst = 1; cyc();
    foreach (m_idx[i]) begin end
    for (int b = 0; b < 5; b++) begin
      idle(); errSET = 16'(1) << ((b < 2) ? b : (b == 2) ? 3 : (b == 3) ? 4 : 6); cyc();
    end
    chk("sat_cnt", 32'(cnt2), 3);
    idle(); cntCLR = 1; cyc();
    chk("cntclr", 32'(cnt2), 0);
    idle(); cntCLR = 1; errSET = 16'h0080; cyc();
    chk("cntclr_evt", 32'(cnt2), 1);

    for (int n = 0; n < 2000; n++) begin
      idle();
      rst      = ($urandom_range(99) == 0);
      init     = ($urandom_range(99) == 0);
      errSET   = 16'($urandom & $urandom & $urandom);
      busy     = ($urandom_range(3) == 0);
      regWR    = ($urandom_range(7) == 0);
      regDATA  = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom & $urandom);
      attnMASK = 16'($urandom);
      attnACK  = ($urandom_range(3) == 0);
      cntCLR   = ($urandom_range(31) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
